// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit with HI/LO result registers.
// Multiplication uses 32 shift-add steps and division uses 32 restoring
// shift-subtract steps, both on operand magnitudes. A final FIX cycle applies
// the sign correction and writes hi/lo. MTHI/MTLO write directly from IDLE.
module md_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [5:0]  count_reg;
  // Shared work register: product {upper, multiplier} for MUL,
  // {remainder, dividend/quotient} for DIV.
  logic [63:0] acc_reg;
  // Multiplicand magnitude (MUL) or divisor magnitude (DIV).
  logic [31:0] opd_reg;
  logic        is_div_reg;
  logic        neg_q_reg;   // product or quotient must be negated
  logic        neg_r_reg;   // remainder must be negated
  logic        dz_reg;      // divisor was zero
  logic [31:0] hi_reg, lo_reg;

  logic        idle_start, signed_op, go_mul, go_div;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic [32:0] div_shift;
  logic [31:0] div_diff;
  logic        div_ge;
  logic [63:0] div_step;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  // Decode an accepted start and form operand magnitudes for signed ops.
  always_comb begin
    idle_start = start && (state_reg == IDLE);
    signed_op  = (op == OP_MULT) || (op == OP_DIV);
    go_mul     = idle_start && ((op == OP_MULT) || (op == OP_MULTU));
    go_div     = idle_start && ((op == OP_DIV) || (op == OP_DIVU));
    a_mag      = (signed_op && a[31]) ? (~a + 32'd1) : a;
    b_mag      = (signed_op && b[31]) ? (~b + 32'd1) : b;
  end

  // One iteration of each algorithm plus the final sign-corrected results.
  always_comb begin
    // Shift-add: conditionally add the multiplicand into the upper half,
    // then shift the whole 65-bit value right by one.
    mul_sum   = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opd_reg} : 33'd0);
    mul_step  = {mul_sum, acc_reg[31:1]};
    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. A zero divisor always "fits", which
    // naturally leaves quotient all ones and remainder = dividend magnitude.
    div_shift = {acc_reg[63:32], acc_reg[31]};
    div_ge    = div_shift >= {1'b0, opd_reg};
    div_diff  = div_shift[31:0] - opd_reg;
    div_step  = div_ge ? {div_diff, acc_reg[30:0], 1'b1}
                       : {div_shift[31:0], acc_reg[30:0], 1'b0};
    prod_fix  = neg_q_reg ? (~acc_reg + 64'd1) : acc_reg;
    rem_fix   = neg_r_reg ? (~acc_reg[63:32] + 32'd1) : acc_reg[63:32];
    if (dz_reg) begin
      quo_fix = 32'hFFFF_FFFF;
    end else begin
      quo_fix = neg_q_reg ? (~acc_reg[31:0] + 32'd1) : acc_reg[31:0];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: 32 iterations in MUL/DIV, then one FIX cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (go_mul) begin
          state_next = MUL;
        end else if (go_div) begin
          state_next = DIV;
        end
      end
      MUL, DIV: begin
        if (count_reg == 6'd31) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, result write and MTHI/MTLO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg  <= 6'd0;
      acc_reg    <= 64'd0;
      opd_reg    <= 32'd0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      dz_reg     <= 1'b0;
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (go_mul) begin
            acc_reg <= {32'd0, b_mag};
            opd_reg <= a_mag;
          end else if (go_div) begin
            acc_reg <= {32'd0, a_mag};
            opd_reg <= b_mag;
          end
          if (go_mul || go_div) begin
            count_reg  <= 6'd0;
            is_div_reg <= go_div;
            neg_q_reg  <= signed_op && (a[31] ^ b[31]);
            neg_r_reg  <= signed_op && a[31];
            dz_reg     <= (b == 32'd0);
          end
          if (idle_start && (op == OP_MTHI)) begin
            hi_reg <= a;
          end
          if (idle_start && (op == OP_MTLO)) begin
            lo_reg <= a;
          end
        end
        MUL: begin
          acc_reg   <= mul_step;
          count_reg <= count_reg + 6'd1;
        end
        DIV: begin
          acc_reg   <= div_step;
          count_reg <= count_reg + 6'd1;
        end
        FIX: begin
          if (is_div_reg) begin
            hi_reg <= rem_fix;
            lo_reg <= quo_fix;
          end else begin
            hi_reg <= prod_fix[63:32];
            lo_reg <= prod_fix[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_reg != IDLE);
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard-based bench for md_unit. Expected {hi,lo} pairs are
// queued when an operation is issued and compared when busy falls.
module tb_md_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int          tests;
  int          fails;
  logic [63:0] sb_q[$];

  md_unit dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference {hi,lo} computed with native 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    model = 64'd0;
    case (o)
      3'd0: model = sx * sy;
      3'd1: model = ux * uy;
      3'd2: begin
        if (y == 32'd0) begin
          model = {x, 32'hFFFF_FFFF};
        end else begin
          q = sx / sy;
          r = sx % sy;
          model = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (y == 32'd0) model = {x, 32'hFFFF_FFFF};
        else            model = {x % y, x / y};
      end
      default: model = 64'd0;
    endcase
  endfunction

  // Issue one iterative op, optionally inject a start during busy, then check
  // busy length, hi/lo stability while busy and the scoreboard result.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int inj_cyc, input logic [2:0] inj_op);
    logic [31:0] hold_hi, hold_lo;
    logic [63:0] exp_v;
    int cyc;
    logic moved;
    sb_q.push_back({exp_hi, exp_lo});
    @(negedge clk);
    hold_hi = hi;
    hold_lo = lo;
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    cyc = 0;
    moved = 1'b0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (hi !== hold_hi || lo !== hold_lo) moved = 1'b1;
      if (cyc == inj_cyc) begin
        start = 1'b1; op = inj_op; a = $urandom; b = $urandom;
      end
      @(negedge clk);
      start = 1'b0;
    end
    tests++;
    if (cyc !== 33) begin
      fails++;
      $display("[TB] FAIL %s busy_cycles: got %0d expected 33", name, cyc);
    end
    tests++;
    if (moved) begin
      fails++;
      $display("[TB] FAIL %s hold_during_busy: hi/lo changed while busy (start %h_%h)", name, hold_hi, hold_lo);
    end
    exp_v = sb_q.pop_front();
    tests++;
    if ({hi, lo} !== exp_v) begin
      fails++;
      $display("[TB] FAIL %s result: got hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo, exp_v[63:32], exp_v[31:0]);
    end
    $display("[TB] %s op=%0d a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d", name, o, av, bv, hi, lo, cyc);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    #1;
    tests++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      fails++;
      $display("[TB] FAIL reset_state: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_release_busy: got %b expected 0", busy);
    end
    $display("[TB] reset busy=%b hi=%h lo=%h", busy, hi, lo);
  endtask

  task automatic test_mult();
    run_op("mult_neg1_x2", 3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 3'd0);
    run_op("mult_neg_neg", 3'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_000F, 0, 3'd0);
  endtask

  task automatic test_multu();
    run_op("multu_max_x2", 3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 0, 3'd0);
  endtask

  task automatic test_div();
    run_op("div_m7_by_2", 3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 3'd0);
    run_op("div_overflow", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 3'd0);
  endtask

  task automatic test_div_zero();
    run_op("divu_7_by_0", 3'd3, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 0, 3'd0);
    run_op("div_m5_by_0", 3'd2, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0, 3'd0);
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] old_lo;
    @(negedge clk);
    old_lo = lo;
    start = 1'b1; op = 3'd4; a = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0; a = 32'd0;
    tests++;
    if (hi !== 32'h1234_5678 || busy !== 1'b0 || lo !== old_lo) begin
      fails++;
      $display("[TB] FAIL mthi: got hi=%h lo=%h busy=%b expected hi=12345678 lo=%h busy=0", hi, lo, busy, old_lo);
    end
    $display("[TB] mthi a=12345678 -> hi=%h lo=%h busy=%b", hi, lo, busy);
    start = 1'b1; op = 3'd5; a = 32'hCAFE_BABE;
    @(negedge clk);
    start = 1'b0; a = 32'd0;
    tests++;
    if (lo !== 32'hCAFE_BABE || busy !== 1'b0 || hi !== 32'h1234_5678) begin
      fails++;
      $display("[TB] FAIL mtlo: got hi=%h lo=%h busy=%b expected hi=12345678 lo=cafebabe busy=0", hi, lo, busy);
    end
    $display("[TB] mtlo a=cafebabe -> hi=%h lo=%h busy=%b", hi, lo, busy);
  endtask

  task automatic test_busy_ignore();
    run_op("mult_mtlo_at10", 3'd0, 32'h0001_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFD_0000, 10, 3'd5);
    run_op("divu_mult_at20", 3'd3, 32'd1000, 32'd7, 32'd6, 32'd142, 20, 3'd0);
  endtask

  task automatic test_back_to_back();
    run_op("div_mult_at_fix", 3'd2, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 33, 3'd0);
    run_op("divu_mthi_at_fix", 3'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 33, 3'd4);
  endtask

  task automatic test_reserved();
    logic [31:0] old_hi, old_lo;
    for (int k = 6; k < 8; k++) begin
      @(negedge clk);
      old_hi = hi;
      old_lo = lo;
      start = 1'b1; op = 3'(k); a = 32'h5A5A_A5A5; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || hi !== old_hi || lo !== old_lo) begin
        fails++;
        $display("[TB] FAIL reserved_op%0d: got busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h",
                 k, busy, hi, lo, old_hi, old_lo);
      end
      $display("[TB] reserved op=%0d -> busy=%b hi=%h lo=%h", k, busy, hi, lo);
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] av, bv;
    logic [63:0] e;
    for (int i = 0; i < 8; i++) begin
      o  = 3'($urandom_range(3, 0));
      av = $urandom;
      if (i == 3)      bv = 32'd0;
      else if (i % 2)  bv = $urandom;
      else             bv = $urandom_range(9, 1);
      if (i == 5)      bv = -bv;
      e = model(o, av, bv);
      run_op("random", o, av, bv, e[63:32], e[31:0], 0, 3'd0);
    end
  endtask

  task automatic test_reset_abort();
    int cyc;
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 15 && busy === 1'b1) begin
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (busy !== 1'b1 || hi === 32'd0) begin
      fails++;
      $display("[TB] FAIL abort_precondition: got busy=%b hi=%h expected busy=1 hi nonzero", busy, hi);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      fails++;
      $display("[TB] FAIL async_reset_abort: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    end
    $display("[TB] reset_abort at busy cycle %0d -> busy=%b hi=%h lo=%h", cyc, busy, hi, lo);
    @(posedge clk);
    #2 rst = 1'b0;
    run_op("multu_after_reset", 3'd1, 32'd3, 32'd5, 32'd0, 32'd15, 0, 3'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_zero();
    test_mthi_mtlo();
    test_busy_ignore();
    test_back_to_back();
    test_reserved();
    test_random();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
